// File: rtl/ext_pipe_if.sv
// ext_pipe_if: handshake bundle for the pipelined immediate extender.
//
// Signals:
//   in_valid / in_ready   producer offers in_imm + in_op; transfer when both high
//   in_imm  [IN_W-1:0]    raw immediate from decode
//   in_op   [2:0]         extension mode
//   out_valid / out_ready extended result handshake towards the operand mux
//   out_data [OUT_W-1:0]  head of the result buffer
//   err                   sticky flag: a reserved mode was accepted
//
// Modports:
//   master  the decode/consumer side that drives the inputs
//   slave   the extender itself
interface ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             err;

    modport master (
        output in_valid, in_imm, in_op, out_ready,
        input  in_ready, out_valid, out_data, err
    );

    modport slave (
        input  in_valid, in_imm, in_op, out_ready,
        output in_ready, out_valid, out_data, err
    );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate-extension unit.
//
// The immediate is extended combinationally at the input according to in_op,
// and only the extended result is written into a 2-entry FIFO. The FIFO head
// drives out_data, so a result accepted in one cycle is visible the next.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset, highest priority
//   flush   synchronous clear of all buffered results (err is kept)
//   bus     ext_pipe_if.slave handshake bundle (see ext_pipe_if.sv)
//
// Modes: 0 zero-ext, 1 sign-ext, 2 load-upper, 3 sign-ext << 2,
//        4 sign-ext low byte, 5 zero-ext low byte, 6/7 reserved (0, sets err).
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    ext_pipe_if.slave     bus
);

    logic [OUT_W-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             err_q;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_result;
    logic             reserved_op;
    logic             accept;
    logic             pop;

    // Extension datapath. Everything is derived from the input bus so the
    // stored entry is already the final operand; op itself never needs to be
    // kept. Mode 3 keeps the low OUT_W bits of the shifted sign-extension,
    // which is the usual branch-offset scaling.
    always_comb begin
        sext        = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
        ext_result  = '0;
        reserved_op = 1'b0;
        case (bus.in_op)
            3'd0:    ext_result = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
            3'd1:    ext_result = sext;
            3'd2:    ext_result = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
            3'd3:    ext_result = {sext[OUT_W-3:0], 2'b00};
            3'd4:    ext_result = {{(OUT_W-8){bus.in_imm[7]}}, bus.in_imm[7:0]};
            3'd5:    ext_result = {{(OUT_W-8){1'b0}}, bus.in_imm[7:0]};
            default: begin
                ext_result  = '0;
                reserved_op = 1'b1;
            end
        endcase
    end

    // Handshake qualification. in_ready comes only from the registered count,
    // so there is no combinational path from out_ready back to in_ready; when
    // full, a same-cycle pop does not open the input until the next cycle.
    always_comb begin
        bus.in_ready  = (count != 2'd2);
        bus.out_valid = (count != 2'd0);
        bus.out_data  = (count != 2'd0) ? mem[rd_ptr] : '0;
        bus.err       = err_q;
        accept        = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
    end

    // FIFO and sticky error state. Reset clears everything; flush empties the
    // buffer and discards any same-cycle input but deliberately leaves err
    // alone so a reserved-op event survives a pipeline flush. With one-bit
    // pointers the wrap from entry 1 back to entry 0 is the natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            err_q  <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= ext_result;
                wr_ptr      <= wr_ptr + 1'b1;
                if (reserved_op) begin
                    err_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: self-checking bench for ext_pipe.
//
// Two instances run side by side: the default 16->32 unit and an 8->16 unit.
// Each has a queue-based reference model holding the expected extended values
// in acceptance order; the extension itself is computed with plain integer
// arithmetic from the mode rules. Every cycle both DUTs are compared to their
// models, then directed scenarios and a randomized phase are applied.
module tb_ext_pipe;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus_a ();
    ext_pipe_if #(.IN_W(8),  .OUT_W(16)) bus_b ();

    ext_pipe #(.IN_W(16), .OUT_W(32)) dut_a (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus_a)
    );

    ext_pipe #(.IN_W(8), .OUT_W(16)) dut_b (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus_b)
    );

    int testsRun  = 0;
    int failCount = 0;

    logic [31:0] exp_a [$];
    logic [15:0] exp_b [$];
    logic        err_a = 1'b0;
    logic        err_b = 1'b0;

    // Reference extension using signed integer arithmetic on the raw value.
    function automatic logic [63:0] refExt(input int inW, input int outW,
                                           input logic [63:0] imm, input int op);
        longint u;
        longint s;
        longint lo;
        longint los;
        longint r;
        logic [63:0] mask;
        mask = (64'd1 << outW) - 64'd1;
        u    = longint'(imm & ((64'd1 << inW) - 64'd1));
        s    = (u >= (longint'(1) << (inW - 1))) ? u - (longint'(1) << inW) : u;
        lo   = u % 256;
        los  = (lo >= 128) ? lo - 256 : lo;
        case (op)
            0:       r = u;
            1:       r = s;
            2:       r = u * (longint'(1) << (outW - inW));
            3:       r = s * 4;
            4:       r = los;
            5:       r = lo;
            default: r = 0;
        endcase
        return logic'(1'b0) ? 64'd0 : (64'(r) & mask);
    endfunction

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: compare both DUTs to their models, then let the models
    // follow the edge using the inputs the bench is currently driving.
    task automatic applyStimulus();
        logic        acc_a, pop_a, rsv_a;
        logic        acc_b, pop_b, rsv_b;
        logic [63:0] t_a, t_b;
        checkOutput("a_in_ready",  64'(bus_a.in_ready),  64'(exp_a.size() != 2));
        checkOutput("a_out_valid", 64'(bus_a.out_valid), 64'(exp_a.size() != 0));
        checkOutput("a_out_data",  64'(bus_a.out_data),  (exp_a.size() != 0) ? 64'(exp_a[0]) : 64'd0);
        checkOutput("a_err",       64'(bus_a.err),       64'(err_a));
        checkOutput("b_in_ready",  64'(bus_b.in_ready),  64'(exp_b.size() != 2));
        checkOutput("b_out_valid", 64'(bus_b.out_valid), 64'(exp_b.size() != 0));
        checkOutput("b_out_data",  64'(bus_b.out_data),  (exp_b.size() != 0) ? 64'(exp_b[0]) : 64'd0);
        checkOutput("b_err",       64'(bus_b.err),       64'(err_b));

        acc_a = bus_a.in_valid && (exp_a.size() != 2);
        pop_a = (exp_a.size() != 0) && bus_a.out_ready;
        rsv_a = (bus_a.in_op >= 3'd6);
        t_a   = refExt(16, 32, 64'(bus_a.in_imm), int'(bus_a.in_op));
        acc_b = bus_b.in_valid && (exp_b.size() != 2);
        pop_b = (exp_b.size() != 0) && bus_b.out_ready;
        rsv_b = (bus_b.in_op >= 3'd6);
        t_b   = refExt(8, 16, 64'(bus_b.in_imm), int'(bus_b.in_op));

        @(posedge clk);
        if (reset) begin
            exp_a.delete();
            exp_b.delete();
            err_a = 1'b0;
            err_b = 1'b0;
        end else if (flush) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (pop_a) void'(exp_a.pop_front());
            if (acc_a) begin
                exp_a.push_back(t_a[31:0]);
                if (rsv_a) err_a = 1'b1;
            end
            if (pop_b) void'(exp_b.pop_front());
            if (acc_b) begin
                exp_b.push_back(t_b[15:0]);
                if (rsv_b) err_b = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic driveA(input logic v, input logic [15:0] imm,
                          input logic [2:0] op, input logic rdy);
        bus_a.in_valid  = v;
        bus_a.in_imm    = imm;
        bus_a.in_op     = op;
        bus_a.out_ready = rdy;
    endtask

    task automatic driveB(input logic v, input logic [7:0] imm,
                          input logic [2:0] op, input logic rdy);
        bus_b.in_valid  = v;
        bus_b.in_imm    = imm;
        bus_b.in_op     = op;
        bus_b.out_ready = rdy;
    endtask

    logic [31:0] dir1 [4] = '{32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010};

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        driveA(1'b0, 16'h0, 3'd0, 1'b0);
        driveB(1'b0, 8'h0, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        applyStimulus();
        reset = 1'b0;
        applyStimulus();

        // Back-to-back modes 0..3 on 16'h8004, each visible one cycle later.
        for (int i = 0; i < 4; i++) begin
            driveA(1'b1, 16'h8004, 3'(i), 1'b1);
            applyStimulus();
            checkOutput($sformatf("mode%0d_8004", i), 64'(bus_a.out_data), 64'(dir1[i]));
        end
        driveA(1'b1, 16'h1280, 3'd4, 1'b1);
        applyStimulus();
        checkOutput("mode4_1280", 64'(bus_a.out_data), 64'h00000000FFFFFF80);
        driveA(1'b1, 16'h1280, 3'd5, 1'b1);
        applyStimulus();
        checkOutput("mode5_1280", 64'(bus_a.out_data), 64'h0000000000000080);
        driveA(1'b1, 16'h0004, 3'd2, 1'b1);
        applyStimulus();
        checkOutput("mode2_0004", 64'(bus_a.out_data), 64'h0000000000040000);
        driveA(1'b0, 16'h0, 3'd0, 1'b1);
        applyStimulus();

        // Fill with the consumer stalled, then drain in order.
        driveA(1'b1, 16'd1, 3'd0, 1'b0);
        applyStimulus();
        driveA(1'b1, 16'd2, 3'd0, 1'b0);
        applyStimulus();
        checkOutput("full_in_ready", 64'(bus_a.in_ready), 64'd0);
        driveA(1'b1, 16'd3, 3'd0, 1'b0);
        applyStimulus();
        applyStimulus();
        checkOutput("full_head", 64'(bus_a.out_data), 64'd1);
        driveA(1'b1, 16'd3, 3'd0, 1'b1);
        applyStimulus();
        checkOutput("drain_head2", 64'(bus_a.out_data), 64'd2);
        checkOutput("reopen_in_ready", 64'(bus_a.in_ready), 64'd1);
        applyStimulus();
        checkOutput("drain_head3", 64'(bus_a.out_data), 64'd3);
        driveA(1'b0, 16'd0, 3'd0, 1'b1);
        applyStimulus();
        checkOutput("drained_valid", 64'(bus_a.out_valid), 64'd0);

        // Steady state at one entry with accept and pop every cycle.
        driveA(1'b1, 16'h0010, 3'd1, 1'b0);
        applyStimulus();
        for (int i = 1; i <= 4; i++) begin
            driveA(1'b1, 16'h0010 + 16'(i), 3'd1, 1'b1);
            applyStimulus();
            checkOutput("steady_head", 64'(bus_a.out_data), 64'h10 + 64'(i));
        end
        driveA(1'b0, 16'h0, 3'd0, 1'b1);
        applyStimulus();

        // Flush with two buffered and a same-cycle offer.
        driveA(1'b1, 16'h00A1, 3'd0, 1'b0);
        applyStimulus();
        driveA(1'b1, 16'h00A2, 3'd0, 1'b0);
        applyStimulus();
        flush = 1'b1;
        driveA(1'b1, 16'h00A3, 3'd0, 1'b1);
        applyStimulus();
        flush = 1'b0;
        driveA(1'b0, 16'h0, 3'd0, 1'b1);
        checkOutput("flush_out_valid", 64'(bus_a.out_valid), 64'd0);
        checkOutput("flush_in_ready",  64'(bus_a.in_ready),  64'd1);
        applyStimulus();
        applyStimulus();

        // Reserved op, flush keeps err, reset mid-stream clears everything.
        driveA(1'b1, 16'h1234, 3'd7, 1'b0);
        applyStimulus();
        checkOutput("rsv_data", 64'(bus_a.out_data), 64'd0);
        checkOutput("rsv_err",  64'(bus_a.err),      64'd1);
        driveA(1'b0, 16'h0, 3'd0, 1'b0);
        flush = 1'b1;
        applyStimulus();
        flush = 1'b0;
        checkOutput("flush_keeps_err", 64'(bus_a.err), 64'd1);
        driveA(1'b1, 16'h0055, 3'd0, 1'b0);
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        driveA(1'b1, 16'h0066, 3'd0, 1'b1);
        applyStimulus();
        reset = 1'b0;
        driveA(1'b0, 16'h0, 3'd0, 1'b1);
        checkOutput("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        checkOutput("rst_out_data",  64'(bus_a.out_data),  64'd0);
        checkOutput("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
        checkOutput("rst_err",       64'(bus_a.err),       64'd0);
        applyStimulus();

        // Narrow instance: 8 -> 16.
        driveB(1'b1, 8'hA5, 3'd2, 1'b1);
        applyStimulus();
        checkOutput("b_mode2_A5", 64'(bus_b.out_data), 64'h000000000000A500);
        driveB(1'b1, 8'h80, 3'd1, 1'b1);
        applyStimulus();
        checkOutput("b_mode1_80", 64'(bus_b.out_data), 64'h000000000000FF80);
        driveB(1'b1, 8'hA5, 3'd3, 1'b1);
        applyStimulus();
        checkOutput("b_mode3_A5", 64'(bus_b.out_data), 64'h000000000000FE94);
        driveB(1'b0, 8'h0, 3'd0, 1'b1);
        applyStimulus();

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            driveA(1'($urandom_range(0, 1)), 16'($urandom),
                   ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5)),
                   ($urandom_range(0, 3) != 0));
            driveB(1'($urandom_range(0, 1)), 8'($urandom),
                   ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5)),
                   ($urandom_range(0, 3) != 0));
            applyStimulus();
        end
        reset = 1'b0;
        flush = 1'b0;
        driveA(1'b0, 16'h0, 3'd0, 1'b1);
        driveB(1'b0, 8'h0, 3'd0, 1'b1);
        applyStimulus();
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
